verin_sample_logger: RTL

Avalon-MM write master that captures 32-bit actuator samples from a valid-strobed source and stores them as a circular log in the 5000-word on-chip memory. It sits directly upstream of the on-chip memory's s1 slave port: its master port drives address/byteenable/chipselect/write/writedata. It absorbs write back-pressure through a small FIFO and reports pointer, wrap and overflow status to software.

---
 rtl/verin_sample_logger.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/verin_sample_logger.sv
// Avalon-MM write master that logs valid-strobed 32-bit samples into a circular
// on-chip memory region, buffering through a small FIFO to ride out waitrequest.
module verin_sample_logger #(
  parameter int DEPTH_WORDS = 5000,
  parameter int ADDR_W      = 13,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [31:0]       sample_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {IDLE, WR} state_t;

  state_t              state_q, state_d;
  logic [31:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       rd_q, rd_d, wp_q, wp_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, addr_q, addr_d, ptr_inc;
  logic [31:0]         data_q, data_d;
  logic                wrapped_q, wrapped_d, overflow_q, overflow_d;
  logic                clr_pend_q, clr_pend_d, busy_q, busy_d;
  logic [15:0]         drops_q, drops_d;

  logic fifo_full, fifo_empty, acc, clr_apply, discard, offer, push, drop, pop, at_end;

  always_comb begin
    fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
    fifo_empty = (cnt_q == '0);
    acc        = (state_q == WR) && !avm_waitrequest;
    // A clear lands immediately when idle, otherwise on the in-flight write's acceptance edge.
    clr_apply  = (clear | clr_pend_q) & ((state_q == IDLE) | acc);
    discard    = clear | clr_apply;
    offer      = sample_valid & enable & ~discard;
    push       = offer & ~fifo_full;
    drop       = offer & fifo_full;
    pop        = ~clr_apply & ~fifo_empty & ((state_q == IDLE) | acc);
    at_end     = (wr_ptr_q == ADDR_W'(DEPTH_WORDS - 1));
    ptr_inc    = at_end ? '0 : wr_ptr_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wp_d       = wp_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wrapped_d  = wrapped_q;
    overflow_d = overflow_q;
    drops_d    = drops_q;
    clr_pend_d = clr_pend_q;
    if (clr_apply) begin
      state_d    = IDLE;
      rd_d       = '0;
      wp_d       = '0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      wrapped_d  = 1'b0;
      overflow_d = 1'b0;
      drops_d    = '0;
      clr_pend_d = 1'b0;
    end else begin
      if (acc) begin
        wr_ptr_d = ptr_inc;
        if (at_end) wrapped_d = 1'b1;
      end
      if (clear && state_q == WR) clr_pend_d = 1'b1;
      if (pop) begin
        state_d = WR;
        data_d  = fifo_mem[rd_q];
        addr_d  = wr_ptr_d;
        rd_d    = rd_q + 1'b1;
      end else if (acc) begin
        state_d = IDLE;
      end
      if (push) wp_d = wp_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drops_q != 16'hFFFF) drops_d = drops_q + 1'b1;
      end
    end
    busy_d = (cnt_d != '0) | (state_d == WR);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp_q] <= sample_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wp_q       <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wrapped_q  <= 1'b0;
      overflow_q <= 1'b0;
      drops_q    <= '0;
      clr_pend_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wrapped_q  <= wrapped_d;
      overflow_q <= overflow_d;
      drops_q    <= drops_d;
      clr_pend_q <= clr_pend_d;
      busy_q     <= busy_d;
    end
  end

  assign avm_write      = (state_q == WR);
  assign avm_chipselect = avm_write;
  assign avm_byteenable = avm_write ? 4'hF : 4'h0;
  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign wr_ptr         = wr_ptr_q;
  assign wrapped        = wrapped_q;
  assign overflow       = overflow_q;
  assign drop_count     = drops_q;
  assign busy           = busy_q;

endmodule
